mem_wb_stage: RTL and testbench

Memory/writeback pipeline stage; the consumer of the execute stage's outputs (control bundle, ALU result, sequential PC, destination register). It captures one instruction per cycle, performs loads and stores over a req/ack data-memory handshake, and stalls upstream while an access is outstanding. It then delivers a one-cycle register-file write pulse with the selected writeback data.

---
 rtl/mem_wb_stage_if.sv | 41 ++++
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Bus bundle for mem_wb_stage: execute-stage inputs, data-memory req/ack port, writeback port.
// slave  : the stage's view (consumes upstream/memory responses, drives requests and writeback).
// master : the surrounding pipeline/memory/testbench view.
interface mem_wb_stage_if;
    // upstream (execute stage) side
    logic [7:0]  bundle_in;
    logic [31:0] alu_in;
    logic [31:0] pc_seq_in;
    logic [31:0] store_data_in;
    logic [4:0]  reg_write_dest_in;
    logic        stall_out;
    // data-memory handshake
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    // register-file writeback
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        align_err;

    modport slave (
        input  bundle_in, alu_in, pc_seq_in, store_data_in, reg_write_dest_in,
        input  dmem_ack, dmem_rdata,
        output stall_out,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output wb_en, wb_dest, wb_data, align_err
    );

    modport master (
        output bundle_in, alu_in, pc_seq_in, store_data_in, reg_write_dest_in,
        output dmem_ack, dmem_rdata,
        input  stall_out,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  wb_en, wb_dest, wb_data, align_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: captures one op per cycle, runs loads/stores over dmem req/ack, emits a one-cycle wb pulse.
// Latency: non-memory op -> wb_en the cycle after the next edge; memory op -> wb_en the cycle after the ack edge.
// Backpressure: stall_out is high for the whole outstanding access; nothing is captured while it is high.
// Ports: clk, reset (async active-low), bus (mem_wb_stage_if.slave: upstream inputs, dmem port, wb port).
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned word/half accesses are dropped and flagged on align_err).
module mem_wb_stage (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_q;
    logic [7:0]  bundle_q;
    logic [31:0] alu_q;
    logic [31:0] pc_seq_q;
    logic [31:0] store_data_q;
    logic [4:0]  dest_q;
    logic        pend_q;        // captured non-memory op still owes its writeback
    logic        wb_en_q;
    logic [4:0]  wb_dest_q;
    logic [31:0] wb_data_q;
    logic        align_err_q;

    logic        in_wait;
    logic        in_mem;
    logic        in_misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] wb_data_d;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        unused_mem_read;

    // mem_read is only needed to classify the op at capture; a set mem_write wins afterwards
    assign unused_mem_read = bundle_q[1];

    assign in_wait = (state_q == WAIT);
    assign in_mem  = bus.bundle_in[1] | bus.bundle_in[2];

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        in_misaligned = 1'b0;
        case (bus.bundle_in[6:5])
            2'b01:   in_misaligned = bus.alu_in[0];
            2'b10:   in_misaligned = 1'b0;
            default: in_misaligned = |bus.alu_in[1:0];  // word and reserved size
        endcase
    end
`else
    assign in_misaligned = 1'b0;
`endif

    // load lane select and extension
    always_comb begin
        ld_byte   = bus.dmem_rdata[7:0];
        load_data = bus.dmem_rdata;
        case (alu_q[1:0])
            2'd1:    ld_byte = bus.dmem_rdata[15:8];
            2'd2:    ld_byte = bus.dmem_rdata[23:16];
            2'd3:    ld_byte = bus.dmem_rdata[31:24];
            default: ld_byte = bus.dmem_rdata[7:0];
        endcase
        ld_half = alu_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (bundle_q[6:5])
            2'b01:   load_data = {{16{bundle_q[7] & ld_half[15]}}, ld_half};
            2'b10:   load_data = {{24{bundle_q[7] & ld_byte[7]}}, ld_byte};
            default: load_data = bus.dmem_rdata;
        endcase
    end

    assign wb_data_d = bundle_q[4] ? pc_seq_q  :
                       bundle_q[3] ? load_data : alu_q;

    // store lane replication and byte enables
    always_comb begin
        st_be    = 4'hF;
        st_wdata = store_data_q;
        case (bundle_q[6:5])
            2'b01: begin
                st_be    = alu_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data_q[15:0]}};
            end
            2'b10: begin
                st_be    = 4'b0001 << alu_q[1:0];
                st_wdata = {4{store_data_q[7:0]}};
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = store_data_q;
            end
        endcase
    end

    // request outputs come straight from state/capture so an async reset drops them at once
    assign bus.stall_out  = in_wait;
    assign bus.dmem_req   = in_wait;
    assign bus.dmem_we    = in_wait & bundle_q[2];
    assign bus.dmem_addr  = in_wait ? {alu_q[31:2], 2'b00} : 32'h0;
    assign bus.dmem_be    = !in_wait ? 4'h0 : (bundle_q[2] ? st_be : 4'hF);
    assign bus.dmem_wdata = (in_wait & bundle_q[2]) ? st_wdata : 32'h0;

    assign bus.wb_en      = wb_en_q;
    assign bus.wb_dest    = wb_dest_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.align_err  = align_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bundle_q     <= 8'h0;
            alu_q        <= 32'h0;
            pc_seq_q     <= 32'h0;
            store_data_q <= 32'h0;
            dest_q       <= 5'h0;
            pend_q       <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_dest_q    <= 5'h0;
            wb_data_q    <= 32'h0;
            align_err_q  <= 1'b0;
        end else begin
            wb_en_q     <= 1'b0;
            align_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // retire the previously captured non-memory op while taking the next one
                    if (pend_q) begin
                        wb_en_q   <= bundle_q[0];
                        wb_dest_q <= dest_q;
                        wb_data_q <= wb_data_d;
                    end
                    bundle_q     <= bus.bundle_in;
                    alu_q        <= bus.alu_in;
                    pc_seq_q     <= bus.pc_seq_in;
                    store_data_q <= bus.store_data_in;
                    dest_q       <= bus.reg_write_dest_in;
                    pend_q       <= 1'b0;
                    if (in_mem && in_misaligned) begin
                        align_err_q <= 1'b1;
                    end else if (in_mem) begin
                        state_q <= WAIT;
                    end else begin
                        pend_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.dmem_ack) begin
                        state_q   <= IDLE;
                        wb_en_q   <= bundle_q[0];
                        wb_dest_q <= dest_q;
                        wb_data_q <= wb_data_d;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, reset-mid-access sequence, then randomized ops
// checked against a transaction-level reference model; writebacks are matched by an expectation queue.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_wb_stage_if bus();
    mem_wb_stage dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0]  bundle;
        logic [31:0] alu;
        logic [31:0] pc_seq;
        logic [31:0] sdata;
        logic [4:0]  dest;
        int          delay;
        logic [31:0] rdata;
        logic        exp_mem;
        logic        exp_misal;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    logic [36:0] wbq[$];
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [7:0] b, input logic [31:0] a, input logic [31:0] pc,
                                 input logic [31:0] sd, input logic [4:0] d, input int dly,
                                 input logic [31:0] rd, input logic m, input logic we,
                                 input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd,
                                 input logic wb, input logic [31:0] wbd);
        vec_t v;
        v = '{b, a, pc, sd, d, dly, rd, m, 1'b0, we, ad, be, wd, wb, wbd};
        return v;
    endfunction

    // reference model: expectations straight from the field definitions using integer arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int unsigned lo, sz;
        logic mem, misal;
        logic [31:0] ld;
        r = v;
        lo = v.alu % 4;
        sz = v.bundle[6:5];
        mem = v.bundle[1] | v.bundle[2];
        misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (sz == 1) misal = (v.alu % 2) != 0;
        else if (sz != 2) misal = (lo != 0);
`endif
        r.exp_mem = mem && !misal;
        r.exp_misal = mem && misal;
        r.exp_we = v.bundle[2];
        r.exp_addr = v.alu - lo;
        r.exp_be = 4'hF;
        r.exp_wdata = v.sdata;
        if (v.bundle[2]) begin
            if (sz == 2) begin
                r.exp_be = 4'(1 << lo);
                r.exp_wdata = (v.sdata & 32'hFF) * 32'h01010101;
            end else if (sz == 1) begin
                r.exp_be = (lo >= 2) ? 4'hC : 4'h3;
                r.exp_wdata = (v.sdata & 32'hFFFF) * 32'h00010001;
            end
        end
        if (sz == 2) begin
            ld = (v.rdata >> (8 * lo)) & 32'hFF;
            if (v.bundle[7] && ld >= 128) ld = ld + 32'hFFFFFF00;
        end else if (sz == 1) begin
            ld = (v.rdata >> ((lo >= 2) ? 16 : 0)) & 32'hFFFF;
            if (v.bundle[7] && ld >= 32768) ld = ld + 32'hFFFF0000;
        end else begin
            ld = v.rdata;
        end
        r.exp_wb_data = v.bundle[4] ? v.pc_seq : (v.bundle[3] ? ld : v.alu);
        r.exp_wb = v.bundle[0] && !r.exp_misal;
        return r;
    endfunction

    // called at a point where the stage is idle; returns at a negedge with the stage idle again
    task automatic run_op(input vec_t v);
        bus.bundle_in = v.bundle;
        bus.alu_in = v.alu;
        bus.pc_seq_in = v.pc_seq;
        bus.store_data_in = v.sdata;
        bus.reg_write_dest_in = v.dest;
        bus.dmem_rdata = $urandom;
        bus.dmem_ack = v.exp_mem ? 1'b0 : 1'($urandom_range(0, 1));  // stray ack while idle
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        if (v.exp_wb) wbq.push_back({v.dest, v.exp_wb_data});
        @(negedge clk);
        chk("align_err", bus.align_err, v.exp_misal);
        chk("req_after_capture", bus.dmem_req, v.exp_mem);
        chk("stall_after_capture", bus.stall_out, v.exp_mem);
        if (v.exp_mem) begin
            for (int c = 0; c <= v.delay; c++) begin
                if (c > 0) @(negedge clk);
                chk("wait_stall", bus.stall_out, 1);
                chk("wait_req", bus.dmem_req, 1);
                chk("dmem_we", bus.dmem_we, v.exp_we);
                chk("dmem_addr", bus.dmem_addr, v.exp_addr);
                chk("dmem_be", bus.dmem_be, v.exp_be);
                if (v.exp_we) chk("dmem_wdata", bus.dmem_wdata, v.exp_wdata);
                bus.dmem_ack = (c == v.delay);
                bus.dmem_rdata = (c == v.delay) ? v.rdata : $urandom;
                @(posedge clk); #1;
                bus.dmem_ack = 1'b0;
                bus.dmem_rdata = $urandom;
            end
            @(negedge clk);
            chk("stall_after_ack", bus.stall_out, 0);
            chk("req_after_ack", bus.dmem_req, 0);
        end
    endtask

    task automatic bubbles(input int n);
        bus.bundle_in = 8'h00;
        bus.dmem_ack = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // writeback monitor: each wb_en pulse must match the oldest expected write
    always @(negedge clk) begin
        if (mon_en && bus.wb_en === 1'b1) begin
            if (wbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got wb_en=1 dest=%0d data=0x%08h expected no write at %0t",
                         bus.wb_dest, bus.wb_data, $time);
            end else begin
                logic [36:0] e;
                e = wbq.pop_front();
                chk("wb_dest", 32'(bus.wb_dest), 32'(e[36:32]));
                chk("wb_data", bus.wb_data, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.bundle_in = 8'h00;
        bus.alu_in = 32'h0;
        bus.pc_seq_in = 32'h0;
        bus.store_data_in = 32'h0;
        bus.reg_write_dest_in = 5'h0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        #1 reset = 1'b0;
        #11;
        chk("rst_stall", bus.stall_out, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_be", bus.dmem_be, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_wb_en", bus.wb_en, 0);
        chk("rst_wb_dest", 32'(bus.wb_dest), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_align_err", bus.align_err, 0);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        //            bundle alu          pc_seq       sdata        dst dly rdata        mem we addr         be    wdata        wb  wb_data
        tbl[0]  = mkv(8'h01, 32'h1234,     32'h0,       32'h0,       5,  0, 32'h0,        0,  0, 32'h0,       4'h0, 32'h0,       1, 32'h1234);
        tbl[1]  = mkv(8'hCB, 32'h103,      32'h0,       32'h0,       7,  2, 32'h80FFFF00, 1,  0, 32'h100,     4'hF, 32'h0,       1, 32'hFFFFFF80);
        tbl[2]  = mkv(8'h24, 32'h202,      32'h0,       32'hAAAABEEF,0,  0, 32'h0,        1,  1, 32'h200,     4'hC, 32'hBEEFBEEF,0, 32'h0);
        tbl[3]  = mkv(8'h11, 32'h55,       32'h400008,  32'h0,       31, 0, 32'h0,        0,  0, 32'h0,       4'h0, 32'h0,       1, 32'h400008);
        tbl[4]  = mkv(8'h0B, 32'h102,      32'h0,       32'h0,       3,  1, 32'h12345678, 1,  0, 32'h100,     4'hF, 32'h0,       1, 32'h12345678);
        tbl[5]  = mkv(8'h2B, 32'h302,      32'h0,       32'h0,       4,  1, 32'h9ABC1234, 1,  0, 32'h300,     4'hF, 32'h0,       1, 32'h00009ABC);
        tbl[6]  = mkv(8'hAB, 32'h300,      32'h0,       32'h0,       6,  0, 32'h12348001, 1,  0, 32'h300,     4'hF, 32'h0,       1, 32'hFFFF8001);
        tbl[7]  = mkv(8'h44, 32'h501,      32'h0,       32'h11223344,0,  1, 32'h0,        1,  1, 32'h500,     4'h2, 32'h44444444,0, 32'h0);
        tbl[8]  = mkv(8'h64, 32'h600,      32'h0,       32'hDEADBEEF,0,  0, 32'h0,        1,  1, 32'h600,     4'hF, 32'hDEADBEEF,0, 32'h0);
        tbl[9]  = mkv(8'h00, 32'h9999,     32'h0,       32'h0,       9,  0, 32'h0,        0,  0, 32'h0,       4'h0, 32'h0,       0, 32'h0);
        tbl[10] = mkv(8'h4B, 32'h700,      32'h0,       32'h0,       10, 3, 32'h000000F0, 1,  0, 32'h700,     4'hF, 32'h0,       1, 32'h000000F0);
        tbl[11] = mkv(8'h06, 32'h800,      32'h0,       32'h01020304,0,  0, 32'h0,        1,  1, 32'h800,     4'hF, 32'h01020304,0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        tbl[4].exp_mem = 1'b0;
        tbl[4].exp_misal = 1'b1;
        tbl[4].exp_wb = 1'b0;
`endif
        for (int i = 0; i < 12; i++) run_op(tbl[i]);
        bubbles(3);

        // reset asserted mid-access while a writeback pulse is also live
        mon_en = 1'b0;
        bus.bundle_in = 8'h01; bus.alu_in = 32'h77; bus.reg_write_dest_in = 5'd9;
        @(posedge clk); #1;
        bus.bundle_in = 8'h0B; bus.alu_in = 32'h40;
        @(posedge clk); #2;
        chk("pre_rst_req", bus.dmem_req, 1);
        chk("pre_rst_wb_en", bus.wb_en, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", bus.dmem_req, 0);
        chk("mid_rst_stall", bus.stall_out, 0);
        chk("mid_rst_wb_en", bus.wb_en, 0);
        chk("mid_rst_align_err", bus.align_err, 0);
        chk("mid_rst_addr", bus.dmem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        wbq.delete();
        bubbles(1);
        mon_en = 1'b1;
        run_op(tbl[1]);
        run_op(tbl[0]);

        // randomized ops against the reference model
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            v.bundle = 8'($urandom);
            if (!(v.bundle[1] | v.bundle[2]) || v.bundle[2]) v.bundle[3] = 1'b0;
            v.alu = $urandom;
            if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
            v.pc_seq = $urandom;
            v.sdata = $urandom;
            v.dest = 5'($urandom);
            v.delay = $urandom_range(0, 3);
            v.rdata = $urandom;
            v = model(v);
            run_op(v);
        end
        bubbles(3);
        chk("wb_pending", wbq.size(), 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
